inv_bus_checker: RTL and testbench

Receive-side checker for an inverted parallel bus driven by a per-lane inverter array. Each lane is decoded by a generate-instantiated inverter, registered, and compared against a fixed expected word. The block counts erroneous samples and reports a pass/fail verdict. It sits at the far end of the bus as a self-checking regression block: a start pulse arms it, it consumes a fixed number of valid samples, then it reports.

---
 rtl/inv_bus_checker.sv | 119 +++++++++++
 tb/tb_inv_bus_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_bus_checker.sv
// Receive-side checker for an inverted parallel bus: decodes each lane, compares it
// against a fixed word, counts erroneous samples over a fixed-length run and reports a verdict.
module inv_bus_checker #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] EXPECT      = WIDTH'(8'b10101010),
    parameter int               NUM_SAMPLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] err_lanes,
    output logic [15:0]      sample_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [15:0] LAST_IDX = 16'(NUM_SAMPLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dec, mism;
    logic [WIDTH-1:0] mism_q, mism_d;
    logic             s1_valid_q, s1_valid_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [WIDTH-1:0] err_lanes_q, err_lanes_d;
    logic [15:0]      sample_count_q, sample_count_d;
    logic             pass_q, pass_d;

    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        assign dec[k]  = ~in_data[k];
        assign mism[k] = dec[k] ^ EXPECT[k];
    end

    always_comb begin
        state_d        = state_q;
        mism_d         = mism;
        s1_valid_d     = in_valid && (state_q == RUN);
        err_count_d    = err_count_q;
        err_lanes_d    = err_lanes_q;
        sample_count_d = sample_count_q;
        pass_d         = pass_q;

        // Stage 2 runs ahead of the FSM so DRAIN can judge on the last sample's result.
        if (s1_valid_q) begin
            err_lanes_d = err_lanes_q | mism_q;
            if ((|mism_q) && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_count_d    = '0;
                    err_lanes_d    = '0;
                    sample_count_d = '0;
                    pass_d         = 1'b0;
                    state_d        = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    sample_count_d = sample_count_q + 16'd1;
                    if (sample_count_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                pass_d  = (err_count_d == 8'd0);
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mism_q         <= '0;
            s1_valid_q     <= 1'b0;
            err_count_q    <= '0;
            err_lanes_q    <= '0;
            sample_count_q <= '0;
            pass_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mism_q         <= mism_d;
            s1_valid_q     <= s1_valid_d;
            err_count_q    <= err_count_d;
            err_lanes_q    <= err_lanes_d;
            sample_count_q <= sample_count_d;
            pass_q         <= pass_d;
        end
    end

    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign pass         = pass_q;
    assign err_count    = err_count_q;
    assign err_lanes    = err_lanes_q;
    assign sample_count = sample_count_q;

endmodule

// File: tb/tb_inv_bus_checker.sv
// Bench for inv_bus_checker: directed vector table, multi-cycle corner sequences and
// randomized runs checked against a sample-list reference model.
module tb_inv_bus_checker;
  localparam logic [7:0] EXP = 8'hAA;
  localparam int NS  = 16;
  localparam int NS2 = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic busy, done, pass;
  logic [7:0] err_count, err_lanes;
  logic [15:0] sample_count;
  logic busy2, done2, pass2;
  logic [7:0] err_count2, err_lanes2;
  logic [15:0] sample_count2;

  inv_bus_checker #(.WIDTH(8), .EXPECT(EXP), .NUM_SAMPLES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .err_lanes(err_lanes), .sample_count(sample_count)
  );

  inv_bus_checker #(.WIDTH(8), .EXPECT(EXP), .NUM_SAMPLES(NS2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_data(in_data),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .err_lanes(err_lanes2), .sample_count(sample_count2)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    int         bad_idx;
    logic [7:0] bad_val;
    logic [7:0] exp_err;
    logic [7:0] exp_lanes;
    logic       exp_pass;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // modes: 0 back-to-back, 1 gapped, 2 ignored-control noise, 3 random
  task automatic run_main(input int mode, input int bad_idx, input logic [7:0] bad_val,
                          input int bad_pct, output int lat_start, output int lat_last,
                          output int mdl_err, output logic [7:0] mdl_lanes);
    int accepted, e_start, last_cyc, guard;
    bit toggle, v;
    logic [7:0] d, m;
    exp_q.delete();
    last_cyc = 0;
    if (mode == 2) begin
      in_valid = 1'b1;
      in_data  = 8'h00;
      tick();
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    e_start = cyc;
    accepted = 0;
    toggle = 1'b1;
    guard = 0;
    while (accepted < NS && guard < 2000) begin
      guard++;
      case (mode)
        1:       v = toggle;
        3:       v = ($urandom_range(0, 3) != 0);
        default: v = 1'b1;
      endcase
      if (!v) d = (mode == 1) ? 8'h00 : 8'($urandom_range(0, 255));
      else if (mode == 3) d = ($urandom_range(0, 99) < bad_pct) ? 8'($urandom_range(0, 255)) : 8'h55;
      else d = (accepted + 1 == bad_idx) ? bad_val : 8'h55;
      if (mode == 2) start = (accepted == 8);
      else if (mode == 3) start = ($urandom_range(0, 7) == 0);
      else start = 1'b0;
      in_valid = v;
      in_data  = d;
      tick();
      if (v) begin
        accepted++;
        exp_q.push_back(d);
        last_cyc = cyc;
      end
      toggle = ~toggle;
    end
    start = 1'b0;
    in_valid = (mode == 2);
    in_data  = 8'h00;
    guard = 0;
    @(negedge clk);
    while (done !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", done, 1);
    lat_start = cyc - e_start;
    lat_last  = cyc - last_cyc;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_low_after_done", busy, 0);
    if (mode == 2) begin
      tick();
      tick();
    end
    in_valid = 1'b0;
    mdl_err = 0;
    mdl_lanes = 8'h00;
    foreach (exp_q[i]) begin
      m = ~exp_q[i] ^ EXP;
      if (m != 8'h00) mdl_err++;
      mdl_lanes |= m;
    end
    if (mdl_err > 255) mdl_err = 255;
    tick();
  endtask

  initial begin
    int ls, ll, me, guard;
    logic [7:0] ml;
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ls, ll, me, guard;
    logic [7:0] ml;
    vecs[0] = '{0,  8'h55, 8'd0, 8'h00, 1'b1};
    vecs[1] = '{5,  8'h54, 8'd1, 8'h01, 1'b0};
    vecs[2] = '{1,  8'h00, 8'd1, 8'h55, 1'b0};
    vecs[3] = '{16, 8'hFF, 8'd1, 8'hAA, 1'b0};
    vecs[4] = '{10, 8'hAA, 8'd1, 8'hFF, 1'b0};

    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_count", err_count, 0);
    check("rst_err_lanes", err_lanes, 0);
    check("rst_sample_count", sample_count, 0);
    check("rst_sat_busy", busy2, 0);
    #10 rst_n = 1'b1;
    tick();

    // directed table: back-to-back runs; done is visible 17 edges past the start edge
    for (int i = 0; i < 5; i++) begin
      run_main(0, vecs[i].bad_idx, vecs[i].bad_val, 0, ls, ll, me, ml);
      check($sformatf("vec%0d_err_count", i), err_count, vecs[i].exp_err);
      check($sformatf("vec%0d_err_lanes", i), err_lanes, vecs[i].exp_lanes);
      check($sformatf("vec%0d_pass", i), pass, vecs[i].exp_pass);
      check($sformatf("vec%0d_sample_count", i), sample_count, 16);
      check($sformatf("vec%0d_start_to_done", i), ls, 17);
    end

    // gapped valid: done follows the edge after the last accepted sample
    run_main(1, 0, 8'h55, 0, ls, ll, me, ml);
    check("gap_pass", pass, 1);
    check("gap_sample_count", sample_count, 16);
    check("gap_err_count", err_count, 0);
    check("gap_last_to_done", ll, 1);

    // ignored controls: bad data in IDLE/DRAIN/DONE, start during RUN
    run_main(2, 0, 8'h55, 0, ls, ll, me, ml);
    check("ign_pass", pass, 1);
    check("ign_err_count", err_count, 0);
    check("ign_err_lanes", err_lanes, 0);
    check("ign_sample_count", sample_count, 16);
    check("ign_start_to_done", ls, 17);

    // reset mid-run after 7 samples, samples 2 and 5 bad
    check("pre_reset_pass", pass, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      in_valid = 1'b1;
      in_data  = (s == 2 || s == 5) ? 8'h00 : 8'h55;
      tick();
    end
    check("pre_reset_err_count", err_count, 2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pass", pass, 0);
    check("mid_rst_err_count", err_count, 0);
    check("mid_rst_err_lanes", err_lanes, 0);
    check("mid_rst_sample_count", sample_count, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);
    run_main(0, 0, 8'h55, 0, ls, ll, me, ml);
    check("post_rst_pass", pass, 1);
    check("post_rst_err_count", err_count, 0);
    check("post_rst_sample_count", sample_count, 16);

    // saturation on the long-run instance: every sample mismatches on all lanes
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int s = 0; s < NS2; s++) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      tick();
    end
    in_valid = 1'b0;
    guard = 0;
    while (done2 !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("sat_done_seen", done2, 1);
    check("sat_err_count", err_count2, 255);
    check("sat_err_lanes", err_lanes2, 8'hFF);
    check("sat_sample_count", sample_count2, NS2);
    check("sat_pass", pass2, 0);
    tick();

    // randomized runs against the reference model
    for (int r = 0; r < 10; r++) begin
      run_main(3, 0, 8'h55, (r % 3 == 0) ? 0 : int'($urandom_range(2, 40)), ls, ll, me, ml);
      check($sformatf("rnd%0d_err_count", r), err_count, me);
      check($sformatf("rnd%0d_err_lanes", r), err_lanes, ml);
      check($sformatf("rnd%0d_pass", r), pass, (me == 0));
      check($sformatf("rnd%0d_sample_count", r), sample_count, 16);
      check($sformatf("rnd%0d_last_to_done", r), ll, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
